// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch: one-outstanding imem request/grant/response into a decode FIFO
module inst_fetch #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] pc_i,
    output logic        pc_stall_o,
    input  logic        flush_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    input  logic        inst_ready_i
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t        state_q;
    state_t        state_d;
    logic [31:0]   pend_pc_q;
    logic [31:0]   data_mem [FIFO_DEPTH];
    logic [31:0]   pc_mem   [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_after;
    logic          push;
    logic          pop;

    // A flush overrides any same-cycle push or pop; the FIFO is simply cleared.
    assign push        = (state_q == WAIT) & imem_rvalid_i & ~flush_i;
    assign pop         = inst_valid_o & inst_ready_i & ~flush_i;
    assign count_after = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            case (state_q)
                IDLE:    state_d = REQ;
                REQ:     state_d = imem_gnt_i ? DROP : REQ;
                WAIT:    state_d = imem_rvalid_i ? REQ : DROP;
                DROP:    state_d = imem_rvalid_i ? REQ : DROP;
                default: state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE:    if (count_q < DEPTH_C) state_d = REQ;
                REQ:     if (imem_gnt_i) state_d = WAIT;
                WAIT:    if (imem_rvalid_i) state_d = (count_after < DEPTH_C) ? REQ : IDLE;
                DROP:    if (imem_rvalid_i) state_d = REQ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        imem_req_o   = (state_q == REQ);
        imem_addr_o  = imem_req_o ? {pc_i[31:2], 2'b00} : 32'h0;
        pc_stall_o   = ~(imem_req_o & imem_gnt_i);
        inst_valid_o = (count_q != '0);
        inst_o       = inst_valid_o ? data_mem[rd_ptr_q] : 32'h0;
        inst_pc_o    = inst_valid_o ? pc_mem[rd_ptr_q] : 32'h0;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pend_pc_q <= 32'h0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            if (imem_req_o && imem_gnt_i) begin
                pend_pc_q <= pc_i;
            end
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                count_q <= count_after;
            end
        end
    end

    // Storage needs no reset: the read side is gated by the occupancy count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            data_mem[wr_ptr_q] <= imem_rdata_i;
            pc_mem[wr_ptr_q]   <= pend_pc_q;
        end
    end

    fifo_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
        !(push && (count_q == DEPTH_C)));

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed bench for inst_fetch with a PC register, imem and decode model
module tb_inst_fetch;
    localparam int DEPTH = 2;

    logic        clk_i;
    logic        reset_i;
    logic [31:0] pc_i;
    logic        pc_stall_o;
    logic        flush_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i;

    inst_fetch #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .pc_i          (pc_i),
        .pc_stall_o    (pc_stall_o),
        .flush_i       (flush_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o),
        .inst_ready_i  (inst_ready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks;
    int fails;

    // memory knobs and state
    int          gnt_delay;
    int          rsp_delay;
    int          gnt_wait;
    int          rsp_cnt;
    logic        rsp_pending;
    logic [31:0] rsp_addr;

    // PC register redirect
    logic        flush_next;
    logic [31:0] flush_target;

    // expectation model: granted pcs awaiting a response, and pcs decode should see in order
    logic [31:0] inflight[$];
    logic [31:0] exp_q[$];
    logic        prev_flush;

    // what decode actually consumed
    logic [31:0] log_pc[$];
    logic [31:0] log_inst[$];
    int          log_cyc[$];
    int          cyc;
    int          req_run;
    int          last_req_len;
    logic        have_first;
    logic [31:0] first_req_addr;

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return {pc[31:2], 2'b00} + 32'h1000;
    endfunction

    function automatic logic [31:0] get_pc(input int i);
        if (i < log_pc.size()) return log_pc[i];
        return 32'hffff_ffff;
    endfunction

    function automatic logic [31:0] get_inst(input int i);
        if (i < log_inst.size()) return log_inst[i];
        return 32'hffff_ffff;
    endfunction

    function automatic int get_cyc(input int i);
        if (i < log_cyc.size()) return log_cyc[i];
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle comparison at the sample point, then advance the model across the coming edge.
    task automatic compare_cycle();
        if (prev_flush) chk("valid_after_flush", {31'b0, inst_valid_o}, 32'd0);
        chk("valid", {31'b0, inst_valid_o}, {31'b0, exp_q.size() != 0});
        if (inst_valid_o && exp_q.size() != 0) begin
            chk("inst_pc", inst_pc_o, exp_q[0]);
            chk("inst", inst_o, word_of(exp_q[0]));
        end
        chk("stall", {31'b0, pc_stall_o}, {31'b0, !(imem_req_o && imem_gnt_i)});
        if (imem_req_o) begin
            chk("addr", imem_addr_o, {pc_i[31:2], 2'b00});
            chk("credit", {31'b0, exp_q.size() < DEPTH}, 32'd1);
            if (!have_first) begin
                have_first     = 1'b1;
                first_req_addr = imem_addr_o;
            end
            req_run++;
            if (imem_gnt_i) begin
                last_req_len = req_run;
                req_run      = 0;
            end
        end else begin
            req_run = 0;
        end

        if (inst_valid_o && inst_ready_i && !flush_i) begin
            log_pc.push_back(inst_pc_o);
            log_inst.push_back(inst_o);
            log_cyc.push_back(cyc);
        end

        if (flush_i) begin
            exp_q.delete();
            inflight.delete();
        end else begin
            if (inst_valid_o && inst_ready_i && exp_q.size() != 0) void'(exp_q.pop_front());
            if (imem_rvalid_i && inflight.size() != 0) exp_q.push_back(inflight.pop_front());
            if (imem_req_o && imem_gnt_i) inflight.push_back(pc_i);
        end
        prev_flush = flush_i;
    endtask

    task automatic tick();
        logic        req_s;
        logic        gnt_s;
        logic        rv_s;
        logic        fl_s;
        logic        stall_s;
        logic [31:0] addr_s;
        @(negedge clk_i);
        cyc++;
        imem_gnt_i    = imem_req_o && (gnt_wait >= gnt_delay);
        imem_rvalid_i = rsp_pending && (rsp_cnt == 0);
        imem_rdata_i  = imem_rvalid_i ? (rsp_addr + 32'h1000) : 32'hdead_beef;
        flush_i       = flush_next;
        #1;
        req_s   = imem_req_o;
        gnt_s   = imem_gnt_i;
        rv_s    = imem_rvalid_i;
        fl_s    = flush_i;
        stall_s = pc_stall_o;
        addr_s  = imem_addr_o;
        compare_cycle();
        @(posedge clk_i);
        #1;
        if (rv_s) rsp_pending = 1'b0;
        else if (rsp_pending && rsp_cnt != 0) rsp_cnt--;
        if (req_s && gnt_s) begin
            rsp_pending = 1'b1;
            rsp_addr    = addr_s;
            rsp_cnt     = rsp_delay - 1;
            gnt_wait    = 0;
        end else if (req_s) begin
            gnt_wait++;
        end
        if (fl_s) pc_i = flush_target;
        else if (!stall_s) pc_i = pc_i + 32'd4;
        flush_next = 1'b0;
        flush_i    = 1'b0;
    endtask

    task automatic do_reset(input logic [31:0] start_pc);
        reset_i       = 1'b1;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        flush_i       = 1'b0;
        flush_next    = 1'b0;
        pc_i          = start_pc;
        repeat (2) @(posedge clk_i);
        #1;
        exp_q.delete();
        inflight.delete();
        log_pc.delete();
        log_inst.delete();
        log_cyc.delete();
        rsp_pending  = 1'b0;
        rsp_cnt      = 0;
        gnt_wait     = 0;
        req_run      = 0;
        last_req_len = 0;
        have_first   = 1'b0;
        prev_flush   = 1'b0;
        cyc          = 0;
        reset_i      = 1'b0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_req"},     {31'b0, imem_req_o},   32'd0);
        chk({tag, "_addr"},    imem_addr_o,           32'd0);
        chk({tag, "_stall"},   {31'b0, pc_stall_o},   32'd1);
        chk({tag, "_valid"},   {31'b0, inst_valid_o}, 32'd0);
        chk({tag, "_inst"},    inst_o,                32'd0);
        chk({tag, "_inst_pc"}, inst_pc_o,             32'd0);
    endtask

    initial begin
        checks = 0;
        fails = 0;
        gnt_delay = 0;
        rsp_delay = 1;
        flush_target = 32'h0;
        first_req_addr = 32'h0;
        reset_i = 1'b1;
        pc_i = 32'h0;
        flush_i = 1'b0;
        flush_next = 1'b0;
        imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i = 32'h0;
        inst_ready_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk_reset_values("rst");

        // continuous fetch, one instruction every two cycles
        inst_ready_i = 1'b1;
        do_reset(32'h0);
        repeat (10) tick();
        chk("cont_first_cyc", get_cyc(0), 32'd4);
        chk("cont_cyc1", get_cyc(1), 32'd6);
        chk("cont_cyc2", get_cyc(2), 32'd8);
        chk("cont_pc0", get_pc(0), 32'h0);
        chk("cont_pc1", get_pc(1), 32'h4);
        chk("cont_pc2", get_pc(2), 32'h8);
        chk("cont_inst0", get_inst(0), 32'h1000);
        chk("cont_inst2", get_inst(2), 32'h1008);

        // back-pressure fills the FIFO, then drains in order
        inst_ready_i = 1'b0;
        do_reset(32'h0);
        repeat (10) tick();
        chk("bp_req", {31'b0, imem_req_o}, 32'd0);
        chk("bp_stall", {31'b0, pc_stall_o}, 32'd1);
        chk("bp_valid", {31'b0, inst_valid_o}, 32'd1);
        chk("bp_head_pc", inst_pc_o, 32'h0);
        chk("bp_pc", pc_i, 32'h8);
        inst_ready_i = 1'b1;
        repeat (10) tick();
        chk("bp_drain0", get_pc(0), 32'h0);
        chk("bp_drain1", get_pc(1), 32'h4);
        chk("bp_resume", get_pc(2), 32'h8);

        // grant delayed by three cycles
        gnt_delay = 3;
        do_reset(32'h0);
        repeat (10) tick();
        chk("gd_req_len", last_req_len, 32'd4);
        chk("gd_outs", log_pc.size(), 32'd1);
        chk("gd_inst", get_inst(0), 32'h1000);
        gnt_delay = 0;

        // flush while waiting for a slow response, redirect to 0x80
        rsp_delay = 3;
        do_reset(32'h0);
        repeat (2) tick();
        flush_next = 1'b1;
        flush_target = 32'h80;
        repeat (14) tick();
        chk("fw_pc0", get_pc(0), 32'h80);
        chk("fw_inst0", get_inst(0), 32'h1080);
        chk("fw_pc1", get_pc(1), 32'h84);

        // flush coincident with grant, then flush coincident with rvalid
        rsp_delay = 1;
        do_reset(32'h0);
        tick();
        flush_next = 1'b1;
        flush_target = 32'h100;
        tick();
        repeat (2) tick();
        flush_next = 1'b1;
        flush_target = 32'h200;
        tick();
        chk("fg_empty", {31'b0, inst_valid_o}, 32'd0);
        repeat (8) tick();
        chk("fg_pc0", get_pc(0), 32'h200);
        chk("fg_inst0", get_inst(0), 32'h1200);

        // misaligned pc
        do_reset(32'h6);
        repeat (6) tick();
        chk("ma_addr", first_req_addr, 32'h4);
        chk("ma_pc", get_pc(0), 32'h6);
        chk("ma_inst", get_inst(0), 32'h1004);

        // reset asserted while waiting for a response
        inst_ready_i = 1'b0;
        do_reset(32'h0);
        repeat (4) tick();
        chk("rw_valid_pre", {31'b0, inst_valid_o}, 32'd1);
        chk("rw_inst_pre", inst_o, 32'h1000);
        reset_i = 1'b1;
        #1;
        chk_reset_values("rw");
        do_reset(32'h0);
        inst_ready_i = 1'b1;
        repeat (6) tick();
        chk("rw_after_pc", get_pc(0), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
